// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART serializer between two byte sources.
// Supports bursts per tenure with a forced yield and an idle-hold revocation timer.
module uart_tx_arbiter #(
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       idle
);

  localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);
  localparam logic [15:0] HOLD_MAX  = 16'(HOLD_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ACK,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        prio;
  logic        owner;
  logic        last_q;
  logic [7:0]  burst_cnt;
  logic [15:0] hold_cnt;
  logic        sel;
  logic        accept;
  logic        release_grant;
  logic        hold_expired;

  always_comb begin
    state_nxt     = state;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    sel           = owner;
    tx_start      = 1'b0;
    release_grant = 1'b0;
    accept        = 1'b0;
    hold_expired  = (hold_cnt == HOLD_MAX - 16'd1);
    case (state)
      S_IDLE: begin
        // prio only breaks ties; a lone valid requester always wins
        sel = (req0_valid && req1_valid) ? prio : req1_valid;
        if (!tx_busy) begin
          req0_ready = req0_valid && !sel;
          req1_ready = req1_valid && sel;
        end
      end
      S_START: begin
        tx_start  = 1'b1;
        state_nxt = S_ACK;
      end
      S_ACK: begin
        if (tx_busy) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!tx_busy) begin
          if (last_q || burst_cnt == BURST_MAX) begin
            release_grant = 1'b1;
            state_nxt     = S_IDLE;
          end else begin
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!tx_busy) begin
          req0_ready = req0_valid && !owner;
          req1_ready = req1_valid && owner;
        end
        if (hold_expired) begin
          release_grant = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (reset) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    accept = req0_ready || req1_ready;
    // a handshake on the timeout cycle keeps the tenure alive
    if (accept) begin
      state_nxt     = S_START;
      release_grant = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      prio      <= 1'b0;
      owner     <= 1'b0;
      last_q    <= 1'b0;
      tx_data   <= 8'h00;
      grant     <= 2'b00;
      burst_cnt <= 8'd0;
      hold_cnt  <= 16'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tx_data   <= sel ? req1_data : req0_data;
        last_q    <= sel ? req1_last : req0_last;
        owner     <= sel;
        grant     <= sel ? 2'b10 : 2'b01;
        burst_cnt <= (state == S_IDLE) ? 8'd1 : burst_cnt + 8'd1;
      end
      if (release_grant) begin
        grant <= 2'b00;
        prio  <= ~owner;
      end
      if (state == S_DRAIN) begin
        hold_cnt <= 16'd0;
      end else if (state == S_HOLD && !accept && hold_cnt != 16'hFFFF) begin
        hold_cnt <= hold_cnt + 16'd1;
      end
    end
  end

  assign idle = (state == S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: two byte sources, a serializer busy model,
// and an expected-send-order queue checked at every start pulse.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_last = 1'b0, req1_last = 1'b0;
  logic       req0_ready, req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [1:0] grant;
  logic       idle;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.MAX_BURST(4), .HOLD_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant      (grant),
    .idle       (idle)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask

  // serializer model: busy rises the cycle after start and lasts busy_len cycles
  logic model_busy;
  int   busy_left;
  int   busy_len = 10;
  logic force_busy = 1'b0;
  assign tx_busy = model_busy | force_busy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_busy <= 1'b0;
      busy_left  <= 0;
    end else if (tx_start) begin
      model_busy <= 1'b1;
      busy_left  <= busy_len;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else if (busy_left == 1) begin
      busy_left  <= 0;
      model_busy <= 1'b0;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] grant;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] cur_exp = 8'h00;
  logic       prev_start = 1'b0;

  task automatic expect_byte(input logic [7:0] d, input logic [1:0] g);
    exp_t e;
    e.data  = d;
    e.grant = g;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (tx_start) begin
        check("start_pulse_width", prev_start, 1'b0);
        if (exp_q.size() == 0) begin
          check("extra_start", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e.data);
          check("grant_at_start", grant, e.grant);
          cur_exp = e.data;
        end
      end
      if (model_busy && busy_left == 1) check("tx_data_hold", tx_data, cur_exp);
    end
    prev_start = tx_start;
  end

  // sources: bit 8 = last, bits 7:0 = data
  logic [8:0] src_q0[$];
  logic [8:0] src_q1[$];

  task automatic drive(input int which, input logic v, input logic [8:0] it);
    if (which == 0) begin
      req0_valid = v; req0_data = it[7:0]; req0_last = it[8];
    end else begin
      req1_valid = v; req1_data = it[7:0]; req1_last = it[8];
    end
  endtask

  task automatic run_src(input int which);
    logic [8:0] it;
    logic       rdy;
    int         waited;
    @(posedge clk); #1;
    forever begin
      if (which == 0) begin
        if (src_q0.size() == 0) break;
        it = src_q0.pop_front();
      end else begin
        if (src_q1.size() == 0) break;
        it = src_q1.pop_front();
      end
      drive(which, 1'b1, it);
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
        rdy = (which == 0) ? req0_ready : req1_ready;
      end while (!rdy && waited < 600);
      if (!rdy) begin
        check("src_handshake", rdy, 1'b1);
        break;
      end
      @(posedge clk); #1;
    end
    // scramble data after the last handshake so late sampling would show up
    drive(which, 1'b0, {1'b0, ~it[7:0]});
  endtask

  task automatic wait_busy(input logic level, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_busy !== level && n < limit);
    check("wait_busy", tx_busy, level);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(idle && exp_q.size() == 0 && !tx_busy) && n < 3000);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("idle_at_end", idle, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, tx_start, 1'b0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_grant"}, grant, 2'b00);
    check({tag, "_idle"}, idle, 1'b1);
    check({tag, "_ready0"}, req0_ready, 1'b0);
    check({tag, "_ready1"}, req1_ready, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b0, 9'h000);
    drive(1, 1'b0, 9'h000);
    force_busy = 1'b0;
    busy_len   = 10;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // ready must be held low during reset even with both sources valid
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #7;
    check_reset_outputs("por");

    // reset in the middle of a DRAIN
    do_reset();
    expect_byte(8'hA5, 2'b01);
    src_q0.push_back({1'b1, 8'hA5});
    run_src(0);
    wait_busy(1'b1, 50);
    reset = 1'b1;
    drive(0, 1'b1, {1'b1, 8'h5A});
    #1;
    check_reset_outputs("rst_drain");
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b0, 9'h000);
    @(negedge clk);
    check_reset_outputs("rst_after");

    // single byte with a long serializer busy
    do_reset();
    busy_len = 80;
    expect_byte(8'h0F, 2'b01);
    src_q0.push_back({1'b1, 8'h0F});
    run_src(0);
    wait_busy(1'b1, 50);
    wait_busy(1'b0, 200);
    check("single_grant_at_fall", grant, 2'b01);
    @(negedge clk);
    check("single_idle_next", idle, 1'b1);
    check("single_grant_released", grant, 2'b00);
    wait_done();

    // contention from reset, then a second round to see prio back on req0
    do_reset();
    expect_byte(8'h11, 2'b01);
    expect_byte(8'h22, 2'b10);
    expect_byte(8'h33, 2'b01);
    expect_byte(8'h44, 2'b10);
    src_q0.push_back({1'b1, 8'h11});
    src_q0.push_back({1'b1, 8'h33});
    src_q1.push_back({1'b1, 8'h22});
    src_q1.push_back({1'b1, 8'h44});
    fork
      run_src(0);
      run_src(1);
    join
    wait_done();

    // burst yield at MAX_BURST=4
    do_reset();
    for (int i = 1; i <= 4; i++) expect_byte(8'(i), 2'b01);
    expect_byte(8'h80, 2'b10);
    expect_byte(8'h05, 2'b01);
    expect_byte(8'h06, 2'b01);
    for (int i = 1; i <= 6; i++) src_q0.push_back({1'b0, 8'(i)});
    src_q1.push_back({1'b1, 8'h80});
    fork
      run_src(0);
      run_src(1);
    join
    wait_done();

    // hold timeout revokes an idle owner
    do_reset();
    expect_byte(8'h41, 2'b01);
    expect_byte(8'h42, 2'b10);
    src_q0.push_back({1'b0, 8'h41});
    run_src(0);
    src_q1.push_back({1'b1, 8'h42});
    fork
      run_src(1);
      begin
        wait_busy(1'b1, 50);
        wait_busy(1'b0, 50);
        k = 0;
        do begin
          @(negedge clk);
          k++;
          if (k == 1) check("hold_ignores_req1", req1_ready, 1'b0);
        end while (grant != 2'b00 && k < 100);
        check("hold_timeout_cycles", k, 17);
      end
    join
    wait_done();

    // busy gating in IDLE
    do_reset();
    force_busy = 1'b1;
    expect_byte(8'h77, 2'b01);
    src_q0.push_back({1'b1, 8'h77});
    fork
      run_src(0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("gate_ready_low", req0_ready, 1'b0);
          check("gate_no_start", tx_start, 1'b0);
        end
        @(posedge clk); #1;
        force_busy = 1'b0;
        @(negedge clk);
        check("gate_ready_high", req0_ready, 1'b1);
        @(negedge clk);
        check("gate_start", tx_start, 1'b1);
      end
    join
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Two-requester round-robin scheduler that shares the single on-board UART transmitter between the CPU's byte output and a second byte source, such as a debug/monitor path. It sits between the byte producers and the UART serializer inside `mother_board`. It grants one owner at a time, supports multi-byte bursts with a forced yield, and sequences the serializer's start/busy handshake.

## Interface
- `MAX_BURST`, 16: maximum bytes one owner sends per tenure before a forced yield; legal range 1..255.
- `HOLD_TIMEOUT`, 1024: cycles an owner may sit idle in HOLD before its grant is revoked; legal range 1..65535.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester has a byte.
- `req0_data` / `req1_data`  in  8  byte to send.
- `req0_last` / `req1_last`  in  1  this byte ends the requester's packet.
- `req0_ready` / `req1_ready`  out  1  byte accepted this cycle when valid&ready.
- `tx_start`  out  1  one-cycle start pulse to the serializer.
- `tx_data`  out  8  byte to the serializer; held stable from the start pulse until busy falls.
- `tx_busy`  in  1  serializer busy; rises after start, falls when the stop bit ends.
- `grant`  out  2  one-hot current owner; 00 means no owner.
- `idle`  out  1  state==IDLE.

## Operation
- States: IDLE, START, ACK, DRAIN, HOLD.
- IDLE:
  - Candidate is the valid requester. If both are valid, the candidate is the one indicated by `prio`; `prio` resets to req0.
  - `ready` goes to the candidate only, and only when `tx_busy`=0.
  - On handshake: latch data into `tx_data`, latch `last`, set `grant`, set `burst_cnt`=1, go to START.
- START: `tx_start`=1 for exactly one cycle, then go to ACK.
- ACK: wait for `tx_busy`=1, then go to DRAIN. There is no timeout here; the serializer is required to acknowledge.
- DRAIN: wait for `tx_busy`=0. Then:
  - If the latched `last`=1 or `burst_cnt`==`MAX_BURST`: release the grant. Set `grant`=00, set `prio` to the other requester, go to IDLE.
  - Otherwise clear `hold_cnt` and go to HOLD.
- HOLD:
  - The owner keeps the grant. Only the owner may get `ready`, and only when `tx_busy`=0. The non-owner is ignored.
  - On handshake: latch data and last, `burst_cnt`+1, go to START.
  - Otherwise `hold_cnt`+1. When `hold_cnt` reaches `HOLD_TIMEOUT`, release exactly as in DRAIN.
- Width rules:
  - `burst_cnt` is 8-bit and never exceeds `MAX_BURST`.
  - `hold_cnt` is 16-bit, saturating, and is cleared on entry to HOLD.
- Requester data is sampled only at the handshake. Changes to `reqN_data` afterwards do not affect `tx_data`.
- `ready` is combinational from state, `prio`, `valid` and `tx_busy`. It is forced to 0 while `reset`=1.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, `tx_start`=0, `tx_data`=0x00, `grant`=00, `idle`=1, `prio`=req0, both `ready`=0, counters=0.
  - An in-flight byte is abandoned. `tx_start` drops the same instant.
- Handshake in cycle N gives `tx_start`=1 in cycle N+1 and ACK from N+2.
- The `tx_busy` fall seen in DRAIN at cycle M gives IDLE or HOLD at M+1. The earliest next accept is M+1, and the next `tx_start` is M+2.
- Per-byte overhead beyond the serializer's busy time is 3 cycles.
- Simultaneous events:
  - Both valid in IDLE: only the `prio` side gets `ready`.
  - HOLD timeout in the same cycle as owner valid: the handshake wins and there is no release.
- `grant` stays stable from the accept of the first byte through the release cycle. It reads 00 from the cycle after release.

## Test plan
- Reset: assert `reset` mid-DRAIN with `tx_data`=0xA5 → all outputs at their reset values immediately, and the same after deassert with no valids.
- Single byte: req0 sends 0x0F with last=1, against a serializer model with WAIT=8 (busy 80 cycles) → one `tx_start` pulse with `tx_data`=0x0F; `grant`=01 until busy falls; `idle`=1 on the next cycle.
- Contention: both valid from reset, req0=0x11 and req1=0x22, both last=1 → 0x11 is sent first, then 0x22; `prio` returns to req0.
- Burst yield: `MAX_BURST`=4; req0 streams 6 bytes 0x01..0x06 with no last; req1 holds 0x80 with last=1 → send order 0x01..0x04, 0x80, 0x05, 0x06.
- Hold timeout: `HOLD_TIMEOUT`=16; req0 sends 0x41 with last=0 then drops valid; req1 is valid → `grant` drops to 00 exactly 16 cycles after HOLD entry, then req1 is served.
- Busy gating: `tx_busy` forced to 1 while in IDLE and req0 is valid → `ready`=0 and no `tx_start` until `tx_busy`=0; the handshake happens the first cycle `tx_busy`=0.
